// File: rtl/fft_bf_datapath_pkg.sv
// Shared constants for the FFT butterfly datapath and its AGU partner: mode encoding,
// transform size, data formats and the common 8-slot butterfly phase map.
package fft_bf_datapath_pkg;

    localparam int unsigned AGU_MODE_WIDTH = 2;
    localparam logic [AGU_MODE_WIDTH-1:0] AGU_MODE_BF_RAM = 2'd2;

    localparam int unsigned LOG_N        = 4;
    localparam int unsigned NO_OF_POINTS = 16;

    localparam int unsigned BF_DATA_WIDTH = 16;
    localparam int unsigned BF_TW_FRAC    = 14;

    typedef logic [2:0] bf_ph_t;

    // Capture slots: the phase during which the RAM word is present on rd_data.
    localparam bf_ph_t BF_PH_BR = 3'd1;
    localparam bf_ph_t BF_PH_WR = 3'd2;
    localparam bf_ph_t BF_PH_BI = 3'd3;
    localparam bf_ph_t BF_PH_WI = 3'd4;
    localparam bf_ph_t BF_PH_AR = 3'd5;
    localparam bf_ph_t BF_PH_AI = 3'd6;

    // Write slots: the phase during which the AGU presents the matching write address.
    localparam bf_ph_t BF_PH_WR1R = 3'd7;
    localparam bf_ph_t BF_PH_WR1I = 3'd0;
    localparam bf_ph_t BF_PH_WR2R = 3'd1;
    localparam bf_ph_t BF_PH_WR2I = 3'd2;

    localparam bf_ph_t BF_PH_IDLE = 3'd7;

endpackage

// File: rtl/fft_bf_datapath_if.sv
// Butterfly datapath bus: controller and RAM read data towards the datapath,
// write data, valid and butterfly count back towards the RAM/controller.
interface fft_bf_datapath_if #(
    parameter int unsigned DATA_WIDTH = fft_bf_datapath_pkg::BF_DATA_WIDTH
);
    import fft_bf_datapath_pkg::*;

    logic [AGU_MODE_WIDTH-1:0] c_mode;
    logic                      c_bf_start;
    logic [DATA_WIDTH-1:0]     rd_data;
    logic [DATA_WIDTH-1:0]     wr_data;
    logic                      bf_valid;
    logic [LOG_N-1:0]          bf_count;

    modport master (
        output c_mode, c_bf_start, rd_data,
        input  wr_data, bf_valid, bf_count
    );

    modport slave (
        input  c_mode, c_bf_start, rd_data,
        output wr_data, bf_valid, bf_count
    );

endinterface

// File: rtl/fft_bf_datapath_cmul.sv
// Registered complex multiply t = b*w with the twiddle fraction shifted out (floor),
// result kept one bit wider than a RAM word.
module fft_bf_datapath_cmul #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned TW_FRAC    = 14
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en_i,
    input  logic signed [DATA_WIDTH-1:0] br_i,
    input  logic signed [DATA_WIDTH-1:0] bi_i,
    input  logic signed [DATA_WIDTH-1:0] wr_i,
    input  logic signed [DATA_WIDTH-1:0] wi_i,
    output logic signed [DATA_WIDTH:0]   tr_o,
    output logic signed [DATA_WIDTH:0]   ti_o
);
    localparam int unsigned PW = 2 * DATA_WIDTH;
    localparam int unsigned SW = PW + 1;
    localparam int unsigned TW = DATA_WIDTH + 1;

    logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
    logic signed [SW-1:0] re_s, im_s;
    logic signed [TW-1:0] tr_d, ti_d, tr_q, ti_q;

    assign p_rr = PW'(br_i) * PW'(wr_i);
    assign p_ii = PW'(bi_i) * PW'(wi_i);
    assign p_ri = PW'(br_i) * PW'(wi_i);
    assign p_ir = PW'(bi_i) * PW'(wr_i);

    assign re_s = (SW'(p_rr) - SW'(p_ii)) >>> TW_FRAC;
    assign im_s = (SW'(p_ri) + SW'(p_ir)) >>> TW_FRAC;

    assign tr_d = TW'(re_s);
    assign ti_d = TW'(im_s);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tr_q <= '0;
            ti_q <= '0;
        end else if (en_i) begin
            tr_q <= tr_d;
            ti_q <= ti_d;
        end
    end

    assign tr_o = tr_q;
    assign ti_o = ti_q;

endmodule

// File: rtl/fft_bf_datapath.sv
// Radix-2 DIT butterfly datapath running lock-step with the AGU 8-slot butterfly cycle:
// captures br,wr,bi,wi,ar,ai from RAM and writes back r1 = a+b*w, r2 = a-b*w.
module fft_bf_datapath
    import fft_bf_datapath_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = BF_DATA_WIDTH,
    parameter int unsigned TW_FRAC    = BF_TW_FRAC,
    parameter int unsigned SCALE      = 1
) (
    input  logic             controlPulse,
    input  logic             reset_n,
    fft_bf_datapath_if.slave bus
);
    localparam int unsigned TW = DATA_WIDTH + 1;
    localparam int unsigned SW = DATA_WIDTH + 2;
    localparam logic [LOG_N-1:0]     CNT_LAST = LOG_N'(NO_OF_POINTS / 2 - 1);
    localparam logic signed [SW-1:0] SAT_MAX  = {3'b000, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0] SAT_MIN  = {3'b111, {(DATA_WIDTH-1){1'b0}}};

    typedef logic signed [DATA_WIDTH-1:0] word_t;

    function automatic word_t scale_sat(input logic signed [SW-1:0] v);
        logic signed [SW-1:0] s;
        s = v >>> SCALE;
        if (s > SAT_MAX) return DATA_WIDTH'(SAT_MAX);
        if (s < SAT_MIN) return DATA_WIDTH'(SAT_MIN);
        return DATA_WIDTH'(s);
    endfunction

    bf_ph_t           ph_q, ph_d;
    logic             active_q, active_d;
    logic             have_q, have_d;
    logic [LOG_N-1:0] cnt_q, cnt_d;
    word_t            br_q, br_d, wr_q, wr_d, bi_q, bi_d, wi_q, wi_d, ar_q, ar_d;
    word_t            r1r_q, r1r_d, r1i_q, r1i_d, r2r_q, r2r_d, r2i_q, r2i_d;

    logic                 bf_mode_c, run_c, cmul_en_c, win_c;
    word_t                rd_s, wr_data_c;
    logic signed [TW-1:0] tr, ti;
    logic signed [SW-1:0] ar_x, ai_x, tr_x, ti_x;

    assign bf_mode_c = (bus.c_mode == AGU_MODE_BF_RAM);
    assign run_c     = bf_mode_c && (active_q || bus.c_bf_start);
    assign cmul_en_c = run_c && (ph_q == BF_PH_AR);
    assign rd_s      = $signed(bus.rd_data);

    fft_bf_datapath_cmul #(
        .DATA_WIDTH (DATA_WIDTH),
        .TW_FRAC    (TW_FRAC)
    ) u_cmul (
        .clk   (controlPulse),
        .rst_n (reset_n),
        .en_i  (cmul_en_c),
        .br_i  (br_q),
        .bi_i  (bi_q),
        .wr_i  (wr_q),
        .wi_i  (wi_q),
        .tr_o  (tr),
        .ti_o  (ti)
    );

    // ai is consumed straight off the read bus in the same slot it arrives.
    assign ar_x = SW'(ar_q);
    assign ai_x = SW'(rd_s);
    assign tr_x = SW'(tr);
    assign ti_x = SW'(ti);

    always_comb begin
        ph_d     = ph_q;
        active_d = active_q;
        have_d   = have_q;
        cnt_d    = cnt_q;
        br_d     = br_q;
        wr_d     = wr_q;
        bi_d     = bi_q;
        wi_d     = wi_q;
        ar_d     = ar_q;
        r1r_d    = r1r_q;
        r1i_d    = r1i_q;
        r2r_d    = r2r_q;
        r2i_d    = r2i_q;
        if (!bf_mode_c) begin
            ph_d     = BF_PH_IDLE;
            active_d = 1'b0;
            have_d   = 1'b0;
            cnt_d    = '0;
        end else if (run_c) begin
            active_d = 1'b1;
            ph_d     = ph_q + 3'd1;
            case (ph_q)
                BF_PH_BR: br_d = rd_s;
                BF_PH_WR: wr_d = rd_s;
                BF_PH_BI: bi_d = rd_s;
                BF_PH_WI: wi_d = rd_s;
                BF_PH_AR: ar_d = rd_s;
                BF_PH_AI: begin
                    r1r_d  = scale_sat(ar_x + tr_x);
                    r1i_d  = scale_sat(ai_x + ti_x);
                    r2r_d  = scale_sat(ar_x - tr_x);
                    r2i_d  = scale_sat(ai_x - ti_x);
                    have_d = 1'b1;
                    cnt_d  = (cnt_q == CNT_LAST) ? '0 : cnt_q + LOG_N'(1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge controlPulse or negedge reset_n) begin
        if (!reset_n) begin
            ph_q     <= BF_PH_IDLE;
            active_q <= 1'b0;
            have_q   <= 1'b0;
            cnt_q    <= '0;
            br_q     <= '0;
            wr_q     <= '0;
            bi_q     <= '0;
            wi_q     <= '0;
            ar_q     <= '0;
            r1r_q    <= '0;
            r1i_q    <= '0;
            r2r_q    <= '0;
            r2i_q    <= '0;
        end else begin
            ph_q     <= ph_d;
            active_q <= active_d;
            have_q   <= have_d;
            cnt_q    <= cnt_d;
            br_q     <= br_d;
            wr_q     <= wr_d;
            bi_q     <= bi_d;
            wi_q     <= wi_d;
            ar_q     <= ar_d;
            r1r_q    <= r1r_d;
            r1i_q    <= r1i_d;
            r2r_q    <= r2r_d;
            r2i_q    <= r2i_d;
        end
    end

    // Previous butterfly's results leave in the write slots while the next one is read.
    always_comb begin
        wr_data_c = '0;
        case (ph_q)
            BF_PH_WR1R: wr_data_c = r1r_q;
            BF_PH_WR1I: wr_data_c = r1i_q;
            BF_PH_WR2R: wr_data_c = r2r_q;
            BF_PH_WR2I: wr_data_c = r2i_q;
            default:    wr_data_c = '0;
        endcase
    end

    assign win_c = (ph_q == BF_PH_WR1R) || (ph_q == BF_PH_WR1I) ||
                   (ph_q == BF_PH_WR2R) || (ph_q == BF_PH_WR2I);

    assign bus.wr_data  = wr_data_c;
    assign bus.bf_valid = active_q && have_q && win_c;
    assign bus.bf_count = cnt_q;

endmodule

// File: tb/tb_fft_bf_datapath.sv
// Bench for fft_bf_datapath: two instances (SCALE=0 and SCALE=1) fed identical RAM data,
// checked cycle by cycle against a plain-arithmetic butterfly model.
module tb_fft_bf_datapath;
    import fft_bf_datapath_pkg::*;

    typedef struct { int ar; int ai; int br; int bi; int wr; int wi; } bf_op_t;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic [AGU_MODE_WIDTH-1:0] mode;
    logic                      start;
    logic [15:0]               rd;

    int     checks = 0;
    int     passes = 0;
    bf_op_t ops[$];
    int     exp0[$];
    int     exp1[$];
    int     obs0[64];
    int     obs1[64];

    always #5 clk = ~clk;

    fft_bf_datapath_if bus0 ();
    fft_bf_datapath_if bus1 ();

    assign bus0.c_mode     = mode;
    assign bus0.c_bf_start = start;
    assign bus0.rd_data    = rd;
    assign bus1.c_mode     = mode;
    assign bus1.c_bf_start = start;
    assign bus1.rd_data    = rd;

    fft_bf_datapath #(.SCALE(0)) dut_s0 (.controlPulse(clk), .reset_n(rst_n), .bus(bus0));
    fft_bf_datapath #(.SCALE(1)) dut_s1 (.controlPulse(clk), .reset_n(rst_n), .bus(bus1));

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] expv);
        checks++;
        assert (obs === expv) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int sat16(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return int'(v);
    endfunction

    function automatic longint wrap17(input longint v);
        logic signed [16:0] t;
        t = 17'(v);
        return longint'(t);
    endfunction

    task automatic model(input bf_op_t op, input int scale,
                         output int r1r, output int r1i, output int r2r, output int r2i);
        longint tr, ti;
        tr  = wrap17((longint'(op.br) * op.wr - longint'(op.bi) * op.wi) >>> 14);
        ti  = wrap17((longint'(op.br) * op.wi + longint'(op.bi) * op.wr) >>> 14);
        r1r = sat16((op.ar + tr) >>> scale);
        r1i = sat16((op.ai + ti) >>> scale);
        r2r = sat16((op.ar - tr) >>> scale);
        r2i = sat16((op.ai - ti) >>> scale);
    endtask

    function automatic int operand(input bf_op_t op, input int p);
        case (p)
            1:       return op.br;
            2:       return op.wr;
            3:       return op.bi;
            4:       return op.wi;
            5:       return op.ar;
            default: return op.ai;
        endcase
    endfunction

    function automatic int rnd16();
        logic signed [15:0] t;
        t = 16'($urandom);
        return int'(t);
    endfunction

    function automatic bf_op_t rnd_op();
        bf_op_t op;
        op.ar = rnd16();
        op.ai = rnd16();
        op.br = rnd16();
        op.bi = rnd16();
        op.wr = int'($urandom_range(32768)) - 16384;
        op.wi = int'($urandom_range(32768)) - 16384;
        return op;
    endfunction

    // Start from idle (ph 7) and stream nbf butterflies; ends with the DUT active at ph 3.
    task automatic run_stream(input int nbf);
        int a, b, c, d;
        exp0.delete();
        exp1.delete();
        for (int j = 0; j < nbf; j++) begin
            model(ops[j], 0, a, b, c, d);
            exp0.push_back(a); exp0.push_back(b); exp0.push_back(c); exp0.push_back(d);
            model(ops[j], 1, a, b, c, d);
            exp1.push_back(a); exp1.push_back(b); exp1.push_back(c); exp1.push_back(d);
        end
        start = 1'b1;
        for (int k = 0; k <= 8 * nbf + 3; k++) begin
            int p, jr, slot, jo;
            p  = (k + 7) % 8;
            jr = (k - 1) / 8;
            if (k >= 1 && p >= 1 && p <= 6 && jr < nbf) rd = 16'(operand(ops[jr], p));
            else rd = 16'($urandom);
            slot = (p == 7) ? 0 : p + 1;
            if (p == 7 || p <= 2) begin
                jo = k - 8 - slot;
                if (jo >= 0) begin
                    jo = jo / 8;
                    check($sformatf("s0 valid k%0d", k), bus0.bf_valid, 1);
                    check($sformatf("s1 valid k%0d", k), bus1.bf_valid, 1);
                    check($sformatf("s0 wr bf%0d slot%0d", jo, slot), $signed(bus0.wr_data), exp0[jo*4+slot]);
                    check($sformatf("s1 wr bf%0d slot%0d", jo, slot), $signed(bus1.wr_data), exp1[jo*4+slot]);
                    obs0[jo*4+slot] = int'($signed(bus0.wr_data));
                    obs1[jo*4+slot] = int'($signed(bus1.wr_data));
                end else begin
                    check($sformatf("s0 early valid k%0d", k), bus0.bf_valid, 0);
                    check($sformatf("s1 early valid k%0d", k), bus1.bf_valid, 0);
                end
            end else begin
                check($sformatf("s0 idle valid k%0d", k), bus0.bf_valid, 0);
                check($sformatf("s1 idle valid k%0d", k), bus1.bf_valid, 0);
                check($sformatf("s0 idle wr k%0d", k), $signed(bus0.wr_data), 0);
                check($sformatf("s1 idle wr k%0d", k), $signed(bus1.wr_data), 0);
            end
            check($sformatf("s0 count k%0d", k), bus0.bf_count, (k / 8) % (NO_OF_POINTS / 2));
            check($sformatf("s1 count k%0d", k), bus1.bf_count, (k / 8) % (NO_OF_POINTS / 2));
            tick();
            start = 1'b0;
        end
    endtask

    task automatic go_idle();
        mode = '0;
        tick();
        mode = AGU_MODE_BF_RAM;
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        mode  = AGU_MODE_BF_RAM;
        start = 1'b0;
        rd    = '0;
        tick();
        tick();
        check("rst s0 wr", $signed(bus0.wr_data), 0);
        check("rst s1 wr", $signed(bus1.wr_data), 0);
        check("rst s0 valid", bus0.bf_valid, 0);
        check("rst s1 valid", bus1.bf_valid, 0);
        check("rst s0 count", bus0.bf_count, 0);
        rst_n = 1'b1;
        tick();

        // Directed: identity, -j, overflow, saturation.
        ops.delete();
        ops.push_back('{1000, 200, 300, -100, 16384, 0});
        ops.push_back('{1000, 200, 300, -100, 0, -16384});
        ops.push_back('{32767, 0, 32767, 0, 16384, 0});
        ops.push_back('{-32768, 0, -32768, 0, 16384, 0});
        run_stream(4);
        check("ident s1 r1r", obs1[0], 650);
        check("ident s1 r1i", obs1[1], 50);
        check("ident s1 r2r", obs1[2], 350);
        check("ident s1 r2i", obs1[3], 150);
        check("negj s0 r1r", obs0[4], 900);
        check("negj s0 r1i", obs0[5], -100);
        check("negj s0 r2r", obs0[6], 1100);
        check("negj s0 r2i", obs0[7], 500);
        check("ovf s1 r1r", obs1[8], 32767);
        check("ovf s1 r2r", obs1[10], 0);
        check("sat s0 r1r", obs0[12], -32768);

        // Mode leaves BF_RAM mid-butterfly; start outside the mode must not arm the block.
        mode = '0;
        tick();
        check("modeoff s0 valid", bus0.bf_valid, 0);
        check("modeoff s1 valid", bus1.bf_valid, 0);
        check("modeoff s0 count", bus0.bf_count, 0);
        check("modeoff s1 count", bus1.bf_count, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        mode  = AGU_MODE_BF_RAM;
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("nostart s0 valid %0d", i), bus0.bf_valid, 0);
            check($sformatf("nostart s1 valid %0d", i), bus1.bf_valid, 0);
            check($sformatf("nostart s0 count %0d", i), bus0.bf_count, 0);
        end

        // Full stage of random butterflies, count wraps after the last.
        ops.delete();
        for (int j = 0; j < NO_OF_POINTS / 2; j++) ops.push_back(rnd_op());
        run_stream(NO_OF_POINTS / 2);

        // Reset asserted at ph 3 with results and a nonzero count held.
        go_idle();
        ops.delete();
        for (int j = 0; j < 2; j++) ops.push_back(rnd_op());
        run_stream(2);
        rst_n = 1'b0;
        #1;
        check("midrst s0 valid", bus0.bf_valid, 0);
        check("midrst s1 valid", bus1.bf_valid, 0);
        check("midrst s0 wr", $signed(bus0.wr_data), 0);
        check("midrst s1 wr", $signed(bus1.wr_data), 0);
        check("midrst s0 count", bus0.bf_count, 0);
        check("midrst s1 count", bus1.bf_count, 0);
        tick();
        rst_n = 1'b1;
        tick();

        ops.delete();
        for (int j = 0; j < 2; j++) ops.push_back(rnd_op());
        run_stream(2);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/fft_bf_datapath.md
Name: fft_bf_datapath

Overview:
- Data-side partner of the FFT address generator in butterfly mode (`AGU_MODE_BF_RAM`).
- The AGU issues the six read addresses per butterfly in the fixed order br, wr, bi, wi, ar, ai. This block captures the returned RAM words in that same order.
- It computes one radix-2 DIT butterfly, r1 = a + b·w and r2 = a − b·w.
- It drives the write-data bus in the slots where the AGU presents write addresses r1r, r1i, r2r, r2i. It runs in lock-step with the AGU's 8-slot butterfly cycle.

Parameters:
- DATA_WIDTH, 16, width of one RAM word (one real or one imaginary part, two's complement).
- TW_FRAC, 14, fractional bits of twiddle words; 1.0 = 2^TW_FRAC.
- SCALE, 1, 1 = arithmetic shift right by 1 on both outputs (per-stage /2); 0 = no scaling.

Ports:
- controlPulse  in  1  clock (same clock as the AGU).
- reset_n  in  1  asynchronous, active-low reset.
- c_mode  in  `AGU_MODE_WIDTH  controller mode; the block is active only in `AGU_MODE_BF_RAM.
- c_bf_start  in  1  one-cycle start pulse, same cycle as the AGU's c_agu_start.
- rd_data  in  DATA_WIDTH  synchronous RAM read data; 1-cycle latency after the read address.
- wr_data  out  DATA_WIDTH  RAM write data, aligned with the AGU write address.
- bf_valid  out  1  high while wr_data carries a computed result.
- bf_count  out  `LOG_N  butterflies completed in the current stage; wraps at `NO_OF_POINTS/2.

Behaviour:
- Reset (async, reset_n=0): ph=7, active=0, all operand/result registers=0, wr_data=0, bf_valid=0, bf_count=0, have_result=0.
- Active flag:
  - set by c_bf_start while c_mode==`AGU_MODE_BF_RAM;
  - cleared whenever c_mode!=`AGU_MODE_BF_RAM. That same clear forces ph=7, bf_count=0, have_result=0, matching the AGU sub-core reset on mode change.
- Phase counter ph (3 bits):
  - increments mod 8 every clock while active or c_bf_start;
  - holds at 7 otherwise.
- Capture schedule (edge taken while ph = value shown):
  - ph1→br, ph2→wr, ph3→bi, ph4→wi, ph5→ar, ph6→ai.
  - Rationale: the AGU registers the address one slot before, and the RAM adds one cycle.
- Complex multiply, registered at the ph5 edge:
  - tr = (br·wr − bi·wi) >>> TW_FRAC;
  - ti = (br·wi + bi·wr) >>> TW_FRAC.
  - Products are full 2·DATA_WIDTH signed; truncation is floor (arithmetic shift).
  - tr/ti are held at DATA_WIDTH+1 bits.
- Butterfly, registered at the ph6 edge into the result bank:
  - inputs are ar (register) and ai (taken directly from rd_data);
  - r1 = a + t, r2 = a − t, computed at DATA_WIDTH+2 bits;
  - then >>> SCALE, then saturated to DATA_WIDTH (max 2^(DW−1)−1, min −2^(DW−1)).
  - The same edge sets have_result=1 and increments bf_count, wrapping at `NO_OF_POINTS/2−1 → 0.
- Output mux (combinational from ph and the result bank):
  - ph7→r1r, ph0→r1i, ph1→r2r, ph2→r2i;
  - all other phases → 0.
  - bf_valid = active & have_result & ph∈{7,0,1,2}.
  - The result bank is not overwritten until the next ph6 edge, so butterfly n is written while butterfly n+1 is being read.
- The first butterfly after start gives bf_valid=0 in its first write window (ph7 immediately after start, before any result exists).
- Twiddle conjugation for IFFT is handled by AGU addressing; this block does no extra work for it.
- c_bf_start while already active is ignored; there is no phase resync.
- Reset mid-butterfly: everything clears immediately; partial operands are discarded.

Decomposition:
- Shared package/defines (00defines.v):
  - `AGU_MODE_BF_RAM, `AGU_MODE_WIDTH, `LOG_N, `NO_OF_POINTS;
  - new `BF_DATA_WIDTH and `BF_TW_FRAC defaults;
  - new phase constants `BF_PH_BR .. `BF_PH_AI and `BF_PH_WR1R .. `BF_PH_WR2I, so the AGU and this block share one slot map.
- One sub-module, bf_cmul: the registered complex multiplier (4 multipliers, 2 adders, shift). Everything else stays in the top.

Test Plan:
- Identity twiddle, SCALE=1: a=(1000,200), b=(300,−100), w=(16384,0).
  - Required: wr_data=650, 50, 350, 150 in ph7, 0, 1, 2 of the next cycle; bf_valid high for exactly those 4 clocks.
- −j twiddle, SCALE=0: same a and b, w=(0,−16384).
  - Required: r1=(900,−100), r2=(1100,500).
- Overflow, SCALE=1: a=(32767,0), b=(32767,0), w=1.0.
  - Required: r1r=32767, r2r=0.
- Saturation, SCALE=0: a=(−32768,0), b=(−32768,0), w=1.0.
  - Required: r1r=−32768 (saturated).
- Stream of `NO_OF_POINTS/2 back-to-back butterflies with distinct operands.
  - Required: each result lands in the slots of the following butterfly; bf_count wraps to 0 after the last.
- Disturbances:
  - reset_n=0 at ph3 → all outputs 0 within the same cycle;
  - c_mode leaving BF_RAM mid-cycle → ph=7, bf_valid=0, no writes until the next c_bf_start.
